// File: rtl/bsg_manycore_run_sequencer.sv
// Launch/run/drain sequencer for a manycore DUT: reset pulse, run until finish, drain to idle, flag timeout.
// Optional deadlock watchdog in RUN is compiled in with `define BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN.
//
// state | meaning
// idle  | waiting for start_i, DUT held in reset
// reset | DUT held in reset for reset_cycles_p cycles
// run   | DUT running, waiting for finish_i
// drain | finish seen, waiting for idle_cycles_p quiet cycles
// done  | completed cleanly, pass
// fail  | timeout (or deadlock), no pass
module bsg_manycore_run_sequencer #(
  parameter int reset_cycles_p    = 10,
  parameter int timeout_cycles_p  = 10000,
  parameter int idle_cycles_p     = 64,
  parameter int deadlock_cycles_p = 1024,
  parameter int num_ports_p       = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic [num_ports_p-1:0] v_i,
  input  logic                   finish_i,
  output logic                   dut_reset_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic                   deadlock_o,
  output logic [31:0]            cycle_count_o
);

  localparam logic [2:0] idle_s  = 3'd0;
  localparam logic [2:0] reset_s = 3'd1;
  localparam logic [2:0] run_s   = 3'd2;
  localparam logic [2:0] drain_s = 3'd3;
  localparam logic [2:0] done_s  = 3'd4;
  localparam logic [2:0] fail_s  = 3'd5;

  localparam int idle_max_lp = (deadlock_cycles_p > idle_cycles_p) ? deadlock_cycles_p : idle_cycles_p;
  localparam int idle_w_lp   = $clog2(idle_max_lp + 1);
  localparam int rst_w_lp    = $clog2(reset_cycles_p + 1);

  logic [2:0]           state_r, state_n;
  logic [rst_w_lp-1:0]  rst_cnt_r;
  logic [idle_w_lp-1:0] idle_cnt_r, idle_cnt_n;
  logic                 active, in_run, timeout_hit, drain_hit, fail_timeout, enter_reset;

  always_comb begin
    active       = |v_i;
    in_run       = (state_r == run_s) || (state_r == drain_s);
    timeout_hit  = in_run && (cycle_count_o == 32'(timeout_cycles_p - 1));
    idle_cnt_n   = active ? '0 : idle_cnt_r + 1'b1;
    drain_hit    = (state_r == drain_s) && (idle_cnt_n == idle_w_lp'(idle_cycles_p));
    enter_reset  = 1'b0;
    fail_timeout = 1'b0;
    state_n      = state_r;
    case (state_r)
      idle_s: if (start_i) state_n = reset_s;
      reset_s: if (rst_cnt_r == rst_w_lp'(reset_cycles_p - 1)) state_n = run_s;
      run_s: begin
        // timeout outranks finish so a late finish cannot mask a blown budget
        if (timeout_hit) begin
          state_n      = fail_s;
          fail_timeout = 1'b1;
        end else if (finish_i) begin
          state_n = drain_s;
        end
`ifdef BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN
        else if (idle_cnt_n == idle_w_lp'(deadlock_cycles_p)) begin
          state_n = fail_s;
        end
`endif
      end
      drain_s: begin
        if (drain_hit) begin
          state_n = done_s;
        end else if (timeout_hit) begin
          state_n      = fail_s;
          fail_timeout = 1'b1;
        end
      end
      done_s, fail_s: if (start_i) state_n = reset_s;
      default: state_n = idle_s;
    endcase
    if ((state_n == reset_s) && (state_r != reset_s)) enter_reset = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= idle_s;
      rst_cnt_r     <= '0;
      idle_cnt_r    <= '0;
      dut_reset_o   <= 1'b1;
      running_o     <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      timeout_o     <= 1'b0;
      cycle_count_o <= '0;
    end else begin
      state_r     <= state_n;
      dut_reset_o <= (state_n == idle_s) || (state_n == reset_s);
      running_o   <= (state_n == run_s) || (state_n == drain_s);
      done_o      <= (state_n == done_s) || (state_n == fail_s);
      pass_o      <= (state_n == done_s);

      if (enter_reset) timeout_o <= 1'b0;
      else if (fail_timeout) timeout_o <= 1'b1;

      if ((state_r == reset_s) && (state_n == reset_s)) rst_cnt_r <= rst_cnt_r + 1'b1;
      else rst_cnt_r <= '0;

      // quiet-cycle counter restarts on every state change, so drain never inherits run history
      if (state_n != state_r) idle_cnt_r <= '0;
`ifdef BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN
      else if (in_run) idle_cnt_r <= idle_cnt_n;
`else
      else if (state_r == drain_s) idle_cnt_r <= idle_cnt_n;
`endif

      if (enter_reset) cycle_count_o <= '0;
      else if (in_run && !timeout_hit && (cycle_count_o != '1)) cycle_count_o <= cycle_count_o + 32'd1;
    end
  end

`ifdef BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) deadlock_o <= 1'b0;
    else if (enter_reset) deadlock_o <= 1'b0;
    else if ((state_r == run_s) && (state_n == fail_s) && !fail_timeout) deadlock_o <= 1'b1;
  end
`else
  assign deadlock_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_run_sequencer.sv
// Randomized bench for bsg_manycore_run_sequencer at default parameters.
// Expected cycle counts come from run/drain arithmetic, not from the RTL structure.
module tb_bsg_manycore_run_sequencer;

  localparam int rst_cyc  = 10;
  localparam int tmo_cyc  = 10000;
  localparam int idle_cyc = 64;
  localparam int dl_cyc   = 1024;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  v_i = '0;
  logic        finish_i = 1'b0;
  logic        dut_reset_o, running_o, done_o, pass_o, timeout_o, deadlock_o;
  logic [31:0] cycle_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  bsg_manycore_run_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .v_i(v_i), .finish_i(finish_i),
    .dut_reset_o(dut_reset_o), .running_o(running_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .deadlock_o(deadlock_o), .cycle_count_o(cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // pulse start and return the number of cycles dut_reset_o stayed high afterwards
  task automatic launch(output int n);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (dut_reset_o === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  // k run cycles of activity; start_i toggles randomly and must be ignored
  task automatic run_for(input int k, input bit nonzero);
    for (int i = 0; i < k; i++) begin
      v_i     = nonzero ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
      start_i = 1'($urandom_range(0, 1));
      step();
    end
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 12000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({dut_reset_o, running_o, done_o, pass_o, timeout_o, deadlock_o} !== 6'b100000 || cycle_count_o !== 0) begin
      n_bad++;
      $display("FAIL reset_values: got rst=%b run=%b done=%b pass=%b tmo=%b dl=%b cnt=%0d required 1 0 0 0 0 0 0",
               dut_reset_o, running_o, done_o, pass_o, timeout_o, deadlock_o, cycle_count_o);
    end
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (dut_reset_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got rst=%b run=%b done=%b required 1 0 0", dut_reset_o, running_o, done_o);
    end
  endtask

  task automatic test_pass_drain();
    int n;
    launch(n);
    n_cmp++;
    if (n !== rst_cyc) begin
      n_bad++;
      $display("FAIL reset_len: got %0d required %0d", n, rst_cyc);
    end
    n_cmp++;
    if (running_o !== 1'b1 || cycle_count_o !== 0) begin
      n_bad++;
      $display("FAIL run_entry: got run=%b cnt=%0d required 1 0", running_o, cycle_count_o);
    end
    run_for(500, 1'b0);
    n_cmp++;
    if (cycle_count_o !== 500 || running_o !== 1'b1) begin
      n_bad++;
      $display("FAIL run_count: got cnt=%0d run=%b required 500 1", cycle_count_o, running_o);
    end
    finish_i = 1'b1;
    v_i = 4'($urandom_range(0, 15));
    step();
    finish_i = 1'b0;
    v_i = '0;
    wait_done(n);
    n_cmp++;
    if (n !== idle_cyc || pass_o !== 1'b1 || timeout_o !== 1'b0 || cycle_count_o !== 565) begin
      n_bad++;
      $display("FAIL drain_done: got drain=%0d pass=%b tmo=%b cnt=%0d required %0d 1 0 565",
               n, pass_o, timeout_o, cycle_count_o, idle_cyc);
    end
    finish_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_i = 4'($urandom_range(0, 15));
      step();
    end
    finish_i = 1'b0;
    n_cmp++;
    if (cycle_count_o !== 565 || done_o !== 1'b1 || pass_o !== 1'b1 || running_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_frozen: got cnt=%0d done=%b pass=%b run=%b required 565 1 1 0",
               cycle_count_o, done_o, pass_o, running_o);
    end
  endtask

  task automatic test_restart();
    int n, f, k, last, drain_n, exp_cnt;
    for (int r = 0; r < 2; r++) begin
      // finish_i held high through RESET must not skip the run
      finish_i = 1'b1;
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
      n_cmp++;
      if (cycle_count_o !== 0 || done_o !== 1'b0 || pass_o !== 1'b0 || dut_reset_o !== 1'b1) begin
        n_bad++;
        $display("FAIL restart_clear: got cnt=%0d done=%b pass=%b rst=%b required 0 0 0 1",
                 cycle_count_o, done_o, pass_o, dut_reset_o);
      end
      n = 0;
      while (dut_reset_o === 1'b1 && n < 100) begin
        step();
        n++;
      end
      finish_i = 1'b0;
      f = $urandom_range(20, 200);
      run_for(f, 1'b0);
      finish_i = 1'b1;
      step();
      finish_i = 1'b0;
      k = $urandom_range(0, 30);
      last = -1;
      for (int j = 0; j < k; j++) begin
        v_i = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        if (v_i != 0) last = j;
        step();
      end
      v_i = '0;
      wait_done(n);
      drain_n = k + n;
      exp_cnt = f + 1 + (last + 1) + idle_cyc;
      n_cmp++;
      if (drain_n !== (last + 1 + idle_cyc) || pass_o !== 1'b1 || cycle_count_o !== 32'(exp_cnt)) begin
        n_bad++;
        $display("FAIL restart_run%0d: got drain=%0d pass=%b cnt=%0d required %0d 1 %0d",
                 r, drain_n, pass_o, cycle_count_o, last + 1 + idle_cyc, exp_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    launch(n);
    v_i = 4'($urandom_range(1, 15));
    n = 0;
    while (done_o !== 1'b1 && n < 12000) begin
      v_i = 4'($urandom_range(1, 15));
      start_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start_i = 1'b0;
    n_cmp++;
    if (n !== tmo_cyc || pass_o !== 1'b0 || timeout_o !== 1'b1 || deadlock_o !== 1'b0 || cycle_count_o !== 32'(tmo_cyc - 1)) begin
      n_bad++;
      $display("FAIL timeout: got cyc=%0d pass=%b tmo=%b dl=%b cnt=%0d required %0d 0 1 0 %0d",
               n, pass_o, timeout_o, deadlock_o, cycle_count_o, tmo_cyc, tmo_cyc - 1);
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (cycle_count_o !== 32'(tmo_cyc - 1) || timeout_o !== 1'b1 || done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fail_frozen: got cnt=%0d tmo=%b done=%b required %0d 1 1", cycle_count_o, timeout_o, done_o, tmo_cyc - 1);
    end
  endtask

  task automatic test_finish_at_timeout();
    int n;
    launch(n);
    run_for(tmo_cyc - 1, 1'b1);
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || pass_o !== 1'b0 || timeout_o !== 1'b1) begin
      n_bad++;
      $display("FAIL finish_vs_timeout: got done=%b pass=%b tmo=%b required 1 0 1", done_o, pass_o, timeout_o);
    end
  endtask

  task automatic test_drain_at_timeout();
    int n;
    launch(n);
    // finish at count tmo-65 puts the last of the 64 quiet cycles on the timeout cycle
    run_for(tmo_cyc - idle_cyc - 1, 1'b1);
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    v_i = '0;
    wait_done(n);
    n_cmp++;
    if (n !== idle_cyc || pass_o !== 1'b1 || timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_vs_timeout: got drain=%0d pass=%b tmo=%b required %0d 1 0", n, pass_o, timeout_o, idle_cyc);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    launch(n);
    run_for(50, 1'b0);
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    v_i = '0;
    for (int i = 0; i < 10; i++) step();
    #1 reset_n_i = 1'b0;
    #1;
    n_cmp++;
    if (dut_reset_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0 || cycle_count_o !== 0) begin
      n_bad++;
      $display("FAIL async_reset: got rst=%b run=%b done=%b pass=%b cnt=%0d required 1 0 0 0 0",
               dut_reset_o, running_o, done_o, pass_o, cycle_count_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (dut_reset_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 || cycle_count_o !== 0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got rst=%b run=%b done=%b cnt=%0d required 1 0 0 0",
               dut_reset_o, running_o, done_o, cycle_count_o);
    end
  endtask

  task automatic test_deadlock();
    int n;
    launch(n);
    run_for(100, 1'b1);
    v_i = '0;
    wait_done(n);
`ifdef BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN
    n_cmp++;
    if (n !== dl_cyc || deadlock_o !== 1'b1 || timeout_o !== 1'b0 || pass_o !== 1'b0) begin
      n_bad++;
      $display("FAIL deadlock: got quiet=%0d dl=%b tmo=%b pass=%b required %0d 1 0 0", n, deadlock_o, timeout_o, pass_o, dl_cyc);
    end
`else
    n_cmp++;
    if (n !== tmo_cyc - 100 || deadlock_o !== 1'b0 || timeout_o !== 1'b1 || cycle_count_o !== 32'(tmo_cyc - 1)) begin
      n_bad++;
      $display("FAIL no_deadlock: got quiet=%0d dl=%b tmo=%b cnt=%0d required %0d 0 1 %0d",
               n, deadlock_o, timeout_o, cycle_count_o, tmo_cyc - 100, tmo_cyc - 1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_drain();
    test_restart();
    test_timeout();
    test_finish_at_timeout();
    test_drain_at_timeout();
    test_reset_mid_drain();
    test_deadlock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_run_sequencer.md
BSG_MANYCORE_RUN_SEQUENCER -- requirements
Module: bsg_manycore_run_sequencer

Interface
REQ-001: The block SHALL have parameter reset_cycles_p, default 10, giving the number of cycles the DUT is held in reset after start.
REQ-002: The block SHALL have parameter timeout_cycles_p, default 10000, giving the run-plus-drain cycle budget before failure.
REQ-003: The block SHALL have parameter idle_cycles_p, default 64, giving the consecutive no-activity cycles that complete a drain.
REQ-004: The block SHALL have parameter deadlock_cycles_p, default 1024, giving the no-activity limit during RUN.
REQ-005: The block SHALL have parameter num_ports_p, default 4, giving the number of monitored network ports.
REQ-006: The block SHALL have input clk_i, 1 bit: the single clock.
REQ-007: The block SHALL have input reset_n_i, 1 bit: reset, asynchronous, active-low.
REQ-008: The block SHALL have input start_i, 1 bit: launch request.
REQ-009: The block SHALL have input v_i, num_ports_p bits: per-port packet valid-and-ready (transfer) strobes.
REQ-010: The block SHALL have input finish_i, 1 bit: program-complete indication from the DUT.
REQ-011: The block SHALL have output dut_reset_o, 1 bit: active-high reset to the manycore DUT.
REQ-012: The block SHALL have output running_o, 1 bit: high in RUN or DRAIN.
REQ-013: The block SHALL have outputs done_o, pass_o, timeout_o and deadlock_o, 1 bit each: completion status.
REQ-014: The block SHALL have output cycle_count_o, 32 bits: cycles spent in RUN and DRAIN.

Function
REQ-015: The FSM SHALL have states IDLE, RESET, RUN, DRAIN, DONE and FAIL; all outputs SHALL be registered.
REQ-016: IDLE SHALL go to RESET when start_i=1, and SHALL otherwise hold.
REQ-017: Entry into RESET SHALL clear cycle_count_o, the idle counter, the reset counter and all status outputs.
REQ-018: dut_reset_o SHALL be 1 in IDLE and in RESET; RESET SHALL last exactly reset_cycles_p cycles and then go to RUN.
REQ-019: In RUN and DRAIN, dut_reset_o SHALL be 0, running_o SHALL be 1, and cycle_count_o SHALL increment by 1 per cycle, saturating at 2^32-1.
REQ-020: Activity SHALL be defined as the OR-reduction of v_i.
REQ-021: RUN SHALL go to DRAIN on finish_i=1; finish_i SHALL be ignored in all other states.
REQ-022: DRAIN SHALL count consecutive inactive cycles, resetting the count on any activity, and SHALL go to DONE when the count reaches idle_cycles_p.
REQ-023: In RUN or DRAIN, when cycle_count_o equals timeout_cycles_p-1, the next state SHALL be FAIL with timeout_o=1.
REQ-024: When drain completion and timeout occur on the same cycle, DONE SHALL win.
REQ-025: When finish_i and timeout occur on the same cycle in RUN, FAIL SHALL win.
REQ-026: DONE SHALL drive done_o=1 and pass_o=1; FAIL SHALL drive done_o=1 and pass_o=0. Both SHALL hold cycle_count_o frozen.
REQ-027: In DONE and FAIL, start_i=1 SHALL restart the sequence via RESET.
REQ-028: start_i SHALL be ignored in RESET, RUN and DRAIN.
REQ-029: Status outputs SHALL change only on state entry.

Reset
REQ-030: Assertion of reset_n_i=0 SHALL immediately force state IDLE with dut_reset_o=1 and all other outputs and counters 0, including mid-run.
REQ-031: Deassertion of reset_n_i SHALL take effect on the next clk_i rising edge, and the block SHALL stay in IDLE until start_i.

Configuration
REQ-032: With macro BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN defined, RUN SHALL count consecutive inactive cycles and go to FAIL with deadlock_o=1 when the count reaches deadlock_cycles_p.
REQ-033: With BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN defined, timeout SHALL take priority over deadlock on the same cycle.
REQ-034: Without BSG_MANYCORE_RUN_SEQ_DEADLOCK_EN, deadlock_o SHALL be tied 0 and no deadlock check SHALL exist.

Verification
REQ-035: Bench SHALL apply start_i pulse with defaults -> dut_reset_o high exactly 10 cycles, then running_o=1.
REQ-036: Bench SHALL drive activity, then finish_i at run cycle 500, then no activity -> DONE after 64 idle cycles, pass_o=1, cycle_count_o=565.
REQ-037: Bench SHALL drive activity with finish_i never asserted -> FAIL at cycle_count_o=9999, timeout_o=1, pass_o=0.
REQ-038: Bench SHALL drive reset_n_i low in DRAIN -> dut_reset_o=1 immediately, done_o=0, cycle_count_o=0, state IDLE.
REQ-039: With DEADLOCK_EN, bench SHALL stop activity at run cycle 100 -> FAIL with deadlock_o=1 after 1024 idle cycles; without the macro -> timeout_o=1 at 9999.
REQ-040: Bench SHALL apply start_i in DONE -> new RESET phase, cycle_count_o cleared, second run passes.
